execute_stage: RTL and testbench

- RV32I pipeline EX stage, placed between the ID/EX register and the MEM stage.
- Selects forwarded operands, runs ALU-control decode and the ALU, and resolves branch condition and target.
- Drives combinational EX results for same-cycle hazard/branch logic.
- Contains the EX/MEM pipeline register, which captures those results on every clock edge.

---
 rtl/execute_stage_pkg.sv | 71 +++++++
 rtl/exec_alu.sv | 38 +++
 rtl/execute_stage.sv | 146 ++++++++++++++
 tb/tb_execute_stage.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/execute_stage_pkg.sv
// Shared encodings for the RV32I execute stage: ALUOp classes, forward selects,
// branch funct3 codes and the internal ALU operation set.
package execute_stage_pkg;

  localparam logic [1:0] ALUOP_MEM  = 2'b00;
  localparam logic [1:0] ALUOP_BR   = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b10;
  localparam logic [1:0] ALUOP_LUI  = 2'b11;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [2:0] F3_ADDSUB = 3'b000;
  localparam logic [2:0] F3_SLL    = 3'b001;
  localparam logic [2:0] F3_SLT    = 3'b010;
  localparam logic [2:0] F3_SLTU   = 3'b011;
  localparam logic [2:0] F3_XOR    = 3'b100;
  localparam logic [2:0] F3_SR     = 3'b101;
  localparam logic [2:0] F3_OR     = 3'b110;
  localparam logic [2:0] F3_AND    = 3'b111;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_PASSB = 4'd10
  } alu_op_e;

  // SUB is only legal for register-register ops; ADDI reuses bit 30 as immediate data.
  function automatic alu_op_e alu_decode(input logic [1:0] alu_op, input logic [2:0] funct3,
                                         input logic funct7_5, input logic alu_src);
    alu_op_e w_op;
    w_op = ALU_ADD;
    case (alu_op)
      ALUOP_MEM: w_op = ALU_ADD;
      ALUOP_BR:  w_op = ALU_SUB;
      ALUOP_LUI: w_op = ALU_PASSB;
      ALUOP_FUNC: begin
        case (funct3)
          F3_ADDSUB: w_op = (funct7_5 && !alu_src) ? ALU_SUB : ALU_ADD;
          F3_SLL:    w_op = ALU_SLL;
          F3_SLT:    w_op = ALU_SLT;
          F3_SLTU:   w_op = ALU_SLTU;
          F3_XOR:    w_op = ALU_XOR;
          F3_SR:     w_op = funct7_5 ? ALU_SRA : ALU_SRL;
          F3_OR:     w_op = ALU_OR;
          F3_AND:    w_op = ALU_AND;
          default:   w_op = ALU_ADD;
        endcase
      end
      default: w_op = ALU_ADD;
    endcase
    return w_op;
  endfunction

endpackage

// File: rtl/exec_alu.sv
// Combinational integer ALU for the execute stage: one decoded operation applied
// to two operands. Shift amount comes from the low bits of operand B.
module exec_alu
  import execute_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  alu_op_e         i_op,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic [XLEN-1:0] o_result
);

  localparam int SHW = $clog2(XLEN);

  logic [SHW-1:0] w_shamt;
  assign w_shamt = i_b[SHW-1:0];

  // ALU operation select
  always_comb begin
    o_result = '0;
    case (i_op)
      ALU_ADD:   o_result = i_a + i_b;
      ALU_SUB:   o_result = i_a - i_b;
      ALU_SLL:   o_result = i_a << w_shamt;
      ALU_SLT:   o_result = {{(XLEN-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
      ALU_SLTU:  o_result = {{(XLEN-1){1'b0}}, (i_a < i_b)};
      ALU_XOR:   o_result = i_a ^ i_b;
      ALU_SRL:   o_result = i_a >> w_shamt;
      ALU_SRA:   o_result = $unsigned($signed(i_a) >>> w_shamt);
      ALU_OR:    o_result = i_a | i_b;
      ALU_AND:   o_result = i_a & i_b;
      ALU_PASSB: o_result = i_b;
      default:   o_result = '0;
    endcase
  end

endmodule

// File: rtl/execute_stage.sv
// RV32I EX stage: operand forwarding, ALU, branch resolution and the EX/MEM
// pipeline register. Everything except the exmem_* outputs is combinational.
module execute_stage
  import execute_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_in,
  input  logic [XLEN-1:0] rs1_data_in,
  input  logic [XLEN-1:0] rs2_data_in,
  input  logic [XLEN-1:0] imm_in,
  input  logic [4:0]      rs1_in,
  input  logic [4:0]      rs2_in,
  input  logic [4:0]      rd_in,
  input  logic [2:0]      funct3_in,
  input  logic            funct7_5_in,
  input  logic            RegWrite_in,
  input  logic            MemRead_in,
  input  logic            MemWrite_in,
  input  logic            MemToReg_in,
  input  logic            ALUSrc_in,
  input  logic            Branch_in,
  input  logic [1:0]      ALUOp_in,
  input  logic [1:0]      forwardA,
  input  logic [1:0]      forwardB,
  input  logic [XLEN-1:0] ex_mem_alu_result,
  input  logic [XLEN-1:0] wb_data,
  output logic [XLEN-1:0] alu_result_out,
  output logic [XLEN-1:0] rs2_data_forwarded_out,
  output logic [4:0]      rd_out,
  output logic            RegWrite_out,
  output logic            MemRead_out,
  output logic            MemWrite_out,
  output logic            MemToReg_out,
  output logic            branch_taken_out,
  output logic [XLEN-1:0] branch_target_out,
  output logic [XLEN-1:0] exmem_alu_result,
  output logic [XLEN-1:0] exmem_rs2_data,
  output logic [4:0]      exmem_rd,
  output logic            exmem_RegWrite,
  output logic            exmem_MemRead,
  output logic            exmem_MemWrite,
  output logic            exmem_MemToReg
);

  logic [XLEN-1:0] w_fwd_a;
  logic [XLEN-1:0] w_fwd_b;
  logic [XLEN-1:0] w_alu_b;
  logic [XLEN-1:0] w_alu_result;
  logic            w_cond;
  alu_op_e         w_alu_op;
  logic            w_unused_ids;

  logic [XLEN-1:0] r_alu_result;
  logic [XLEN-1:0] r_rs2_data;
  logic [4:0]      r_rd;
  logic            r_reg_write;
  logic            r_mem_read;
  logic            r_mem_write;
  logic            r_mem_to_reg;

  // Source ids arrive only to keep the ID/EX interface uniform.
  assign w_unused_ids = ^{rs1_in, rs2_in};

  // Operand forwarding muxes; select 11 falls back to register data
  always_comb begin
    w_fwd_a = rs1_data_in;
    w_fwd_b = rs2_data_in;
    case (forwardA)
      FWD_MEM: w_fwd_a = ex_mem_alu_result;
      FWD_WB:  w_fwd_a = wb_data;
      default: w_fwd_a = rs1_data_in;
    endcase
    case (forwardB)
      FWD_MEM: w_fwd_b = ex_mem_alu_result;
      FWD_WB:  w_fwd_b = wb_data;
      default: w_fwd_b = rs2_data_in;
    endcase
  end

  assign w_alu_b  = ALUSrc_in ? imm_in : w_fwd_b;
  assign w_alu_op = alu_decode(ALUOp_in, funct3_in, funct7_5_in, ALUSrc_in);

  exec_alu #(.XLEN(XLEN)) u_alu (
    .i_op     (w_alu_op),
    .i_a      (w_fwd_a),
    .i_b      (w_alu_b),
    .o_result (w_alu_result)
  );

  // Branch condition always compares the forwarded registers, never the immediate
  always_comb begin
    w_cond = 1'b0;
    case (funct3_in)
      F3_BEQ:  w_cond = (w_fwd_a == w_fwd_b);
      F3_BNE:  w_cond = (w_fwd_a != w_fwd_b);
      F3_BLT:  w_cond = ($signed(w_fwd_a) <  $signed(w_fwd_b));
      F3_BGE:  w_cond = ($signed(w_fwd_a) >= $signed(w_fwd_b));
      F3_BLTU: w_cond = (w_fwd_a <  w_fwd_b);
      F3_BGEU: w_cond = (w_fwd_a >= w_fwd_b);
      default: w_cond = 1'b0;
    endcase
  end

  assign alu_result_out         = w_alu_result;
  assign rs2_data_forwarded_out = w_fwd_b;
  assign rd_out                 = rd_in;
  assign RegWrite_out           = RegWrite_in;
  assign MemRead_out            = MemRead_in;
  assign MemWrite_out           = MemWrite_in;
  assign MemToReg_out           = MemToReg_in;
  assign branch_taken_out       = Branch_in & w_cond;
  assign branch_target_out      = pc_in + imm_in;

  // EX/MEM pipeline register; reset yields a write-free NOP
  always_ff @(posedge clk) begin
    if (rst) begin
      r_alu_result <= '0;
      r_rs2_data   <= '0;
      r_rd         <= 5'd0;
      r_reg_write  <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
    end else begin
      r_alu_result <= w_alu_result;
      r_rs2_data   <= w_fwd_b;
      r_rd         <= rd_in;
      r_reg_write  <= RegWrite_in;
      r_mem_read   <= MemRead_in;
      r_mem_write  <= MemWrite_in;
      r_mem_to_reg <= MemToReg_in;
    end
  end

  assign exmem_alu_result = r_alu_result;
  assign exmem_rs2_data   = r_rs2_data;
  assign exmem_rd         = r_rd;
  assign exmem_RegWrite   = r_reg_write;
  assign exmem_MemRead    = r_mem_read;
  assign exmem_MemWrite   = r_mem_write;
  assign exmem_MemToReg   = r_mem_to_reg;

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: directed vector table, reset sequences
// and randomized traffic against an arithmetic reference model.
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_in, rs1_data_in, rs2_data_in, imm_in, ex_mem_alu_result, wb_data;
  logic [4:0]  rs1_in, rs2_in, rd_in;
  logic [2:0]  funct3_in;
  logic        funct7_5_in, RegWrite_in, MemRead_in, MemWrite_in, MemToReg_in;
  logic        ALUSrc_in, Branch_in;
  logic [1:0]  ALUOp_in, forwardA, forwardB;
  logic [31:0] alu_result_out, rs2_data_forwarded_out, branch_target_out;
  logic [4:0]  rd_out;
  logic        RegWrite_out, MemRead_out, MemWrite_out, MemToReg_out, branch_taken_out;
  logic [31:0] exmem_alu_result, exmem_rs2_data;
  logic [4:0]  exmem_rd;
  logic        exmem_RegWrite, exmem_MemRead, exmem_MemWrite, exmem_MemToReg;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  execute_stage #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .pc_in(pc_in), .rs1_data_in(rs1_data_in), .rs2_data_in(rs2_data_in),
    .imm_in(imm_in), .rs1_in(rs1_in), .rs2_in(rs2_in), .rd_in(rd_in), .funct3_in(funct3_in),
    .funct7_5_in(funct7_5_in), .RegWrite_in(RegWrite_in), .MemRead_in(MemRead_in),
    .MemWrite_in(MemWrite_in), .MemToReg_in(MemToReg_in), .ALUSrc_in(ALUSrc_in),
    .Branch_in(Branch_in), .ALUOp_in(ALUOp_in), .forwardA(forwardA), .forwardB(forwardB),
    .ex_mem_alu_result(ex_mem_alu_result), .wb_data(wb_data),
    .alu_result_out(alu_result_out), .rs2_data_forwarded_out(rs2_data_forwarded_out),
    .rd_out(rd_out), .RegWrite_out(RegWrite_out), .MemRead_out(MemRead_out),
    .MemWrite_out(MemWrite_out), .MemToReg_out(MemToReg_out),
    .branch_taken_out(branch_taken_out), .branch_target_out(branch_target_out),
    .exmem_alu_result(exmem_alu_result), .exmem_rs2_data(exmem_rs2_data), .exmem_rd(exmem_rd),
    .exmem_RegWrite(exmem_RegWrite), .exmem_MemRead(exmem_MemRead),
    .exmem_MemWrite(exmem_MemWrite), .exmem_MemToReg(exmem_MemToReg)
  );

  typedef struct {
    logic [1:0]  fa, fb;
    logic [31:0] rs1, rs2, imm, exm, wb, pc;
    logic [2:0]  f3;
    logic        f7;
    logic [1:0]  op;
    logic        src, br;
    logic [31:0] e_alu, e_fwdb;
    logic        e_tk;
    logic [31:0] e_tgt;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pick(input logic [1:0] f, input logic [31:0] r);
    if (f == 2'b10) return ex_mem_alu_result;
    else if (f == 2'b01) return wb_data;
    else return r;
  endfunction

  // Reference ALU in 64-bit integer arithmetic, truncated to 32 bits.
  function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b);
    longint ua, ub, sa, sb, r;
    int sh;
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sh = int'(b[4:0]);
    r  = 0;
    case (ALUOp_in)
      2'b00: r = ua + ub;
      2'b01: r = ua - ub;
      2'b11: r = ub;
      default: begin
        case (funct3_in)
          3'd0: r = (funct7_5_in && !ALUSrc_in) ? ua - ub : ua + ub;
          3'd1: r = ua * (longint'(1) << sh);
          3'd2: r = (sa < sb) ? 1 : 0;
          3'd3: r = (ua < ub) ? 1 : 0;
          3'd4: r = ua ^ ub;
          3'd5: r = funct7_5_in ? (sa >>> sh) : (ua / (longint'(1) << sh));
          3'd6: r = ua | ub;
          default: r = ua & ub;
        endcase
      end
    endcase
    return r[31:0];
  endfunction

  function automatic logic ref_br(input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    logic c;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (funct3_in)
      3'd0: c = (a == b);
      3'd1: c = (a != b);
      3'd4: c = (sa < sb);
      3'd5: c = (sa >= sb);
      3'd6: c = (a < b);
      3'd7: c = (a >= b);
      default: c = 1'b0;
    endcase
    return Branch_in && c;
  endfunction

  task automatic apply(input vec_t v);
    forwardA = v.fa; forwardB = v.fb; rs1_data_in = v.rs1; rs2_data_in = v.rs2;
    imm_in = v.imm; ex_mem_alu_result = v.exm; wb_data = v.wb; pc_in = v.pc;
    funct3_in = v.f3; funct7_5_in = v.f7; ALUOp_in = v.op; ALUSrc_in = v.src; Branch_in = v.br;
  endtask

  task automatic chk_exmem_zero();
    chk("rst_alu", exmem_alu_result, 32'd0);
    chk("rst_rs2", exmem_rs2_data, 32'd0);
    chk("rst_rd", {27'd0, exmem_rd}, 32'd0);
    chk("rst_ctl", {28'd0, exmem_RegWrite, exmem_MemRead, exmem_MemWrite, exmem_MemToReg}, 32'd0);
  endtask

  initial begin
    logic [31:0] a, b, e_alu, e_tgt;
    logic        e_tk;
    logic [3:0]  e_ctl;
    logic [4:0]  e_rd;

    //           fa     fb     rs1            rs2            imm            exm     wb     pc       f3    f7    op     src   br    e_alu          e_fwdb         tk    tgt
    vecs[0]  = '{2'b00, 2'b00, 32'd10,        32'd20,        32'd0,         32'd0,  32'd0, 32'd0,   3'd0, 1'b0, 2'b10, 1'b0, 1'b0, 32'd30,        32'd20,        1'b0, 32'd0};
    vecs[1]  = '{2'b00, 2'b00, 32'd5,         32'd0,         32'd7,         32'd0,  32'd0, 32'd0,   3'd0, 1'b0, 2'b10, 1'b1, 1'b0, 32'd12,        32'd0,         1'b0, 32'd7};
    vecs[2]  = '{2'b00, 2'b00, 32'd5,         32'd0,         32'd7,         32'd0,  32'd0, 32'd0,   3'd0, 1'b1, 2'b10, 1'b1, 1'b0, 32'd12,        32'd0,         1'b0, 32'd7};
    vecs[3]  = '{2'b00, 2'b00, 32'd20,        32'd30,        32'd0,         32'd0,  32'd0, 32'd0,   3'd0, 1'b1, 2'b10, 1'b0, 1'b0, 32'hFFFFFFF6,  32'd30,        1'b0, 32'd0};
    vecs[4]  = '{2'b10, 2'b00, 32'd0,         32'd0,         32'd1,         32'd42, 32'd0, 32'd0,   3'd0, 1'b0, 2'b00, 1'b1, 1'b0, 32'd43,        32'd0,         1'b0, 32'd1};
    vecs[5]  = '{2'b00, 2'b01, 32'd1,         32'd77,        32'd0,         32'd0,  32'd9, 32'd0,   3'd0, 1'b0, 2'b00, 1'b0, 1'b0, 32'd10,        32'd9,         1'b0, 32'd0};
    vecs[6]  = '{2'b00, 2'b00, 32'd15,        32'd15,        32'd16,        32'd0,  32'd0, 32'd200, 3'd0, 1'b0, 2'b01, 1'b0, 1'b1, 32'd0,         32'd15,        1'b1, 32'd216};
    vecs[7]  = '{2'b00, 2'b00, 32'd15,        32'd15,        32'd16,        32'd0,  32'd0, 32'd200, 3'd1, 1'b0, 2'b01, 1'b0, 1'b1, 32'd0,         32'd15,        1'b0, 32'd216};
    vecs[8]  = '{2'b00, 2'b00, 32'hFFFFFFFF,  32'd1,         32'd16,        32'd0,  32'd0, 32'd200, 3'd4, 1'b0, 2'b01, 1'b0, 1'b1, 32'hFFFFFFFE,  32'd1,         1'b1, 32'd216};
    vecs[9]  = '{2'b00, 2'b00, 32'hFFFFFFFF,  32'd1,         32'd16,        32'd0,  32'd0, 32'd200, 3'd6, 1'b0, 2'b01, 1'b0, 1'b1, 32'hFFFFFFFE,  32'd1,         1'b0, 32'd216};
    vecs[10] = '{2'b00, 2'b00, 32'd15,        32'd15,        32'd16,        32'd0,  32'd0, 32'd200, 3'd0, 1'b0, 2'b01, 1'b0, 1'b0, 32'd0,         32'd15,        1'b0, 32'd216};
    vecs[11] = '{2'b00, 2'b00, 32'h80000000,  32'd0,         32'd4,         32'd0,  32'd0, 32'd0,   3'd5, 1'b1, 2'b10, 1'b1, 1'b0, 32'hF8000000,  32'd0,         1'b0, 32'd4};
    vecs[12] = '{2'b00, 2'b00, 32'h80000000,  32'd0,         32'd4,         32'd0,  32'd0, 32'd0,   3'd5, 1'b0, 2'b10, 1'b1, 1'b0, 32'h08000000,  32'd0,         1'b0, 32'd4};
    vecs[13] = '{2'b00, 2'b00, 32'd1,         32'hFFFFFFFF,  32'd0,         32'd0,  32'd0, 32'd0,   3'd3, 1'b0, 2'b10, 1'b0, 1'b0, 32'd1,         32'hFFFFFFFF,  1'b0, 32'd0};
    vecs[14] = '{2'b00, 2'b00, 32'd99,        32'd0,         32'h12345000,  32'd0,  32'd0, 32'd0,   3'd0, 1'b0, 2'b11, 1'b1, 1'b0, 32'h12345000,  32'd0,         1'b0, 32'h12345000};
    vecs[15] = '{2'b11, 2'b11, 32'd7,         32'd3,         32'd0,         32'd100,32'd200,32'd0,  3'd0, 1'b0, 2'b00, 1'b0, 1'b0, 32'd10,        32'd3,         1'b0, 32'd0};
    vecs[16] = '{2'b00, 2'b00, 32'hFFFFFFFF,  32'd1,         32'd16,        32'd0,  32'd0, 32'd200, 3'd7, 1'b0, 2'b01, 1'b0, 1'b1, 32'hFFFFFFFE,  32'd1,         1'b1, 32'd216};

    rst = 1'b1;
    apply(vecs[0]);
    rs1_in = 5'd0; rs2_in = 5'd0; rd_in = 5'd0;
    RegWrite_in = 1'b0; MemRead_in = 1'b0; MemWrite_in = 1'b0; MemToReg_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_exmem_zero();

    // Directed vectors
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      rst = 1'b0;
      apply(vecs[i]);
      rd_in = 5'(i + 3);
      {RegWrite_in, MemRead_in, MemWrite_in, MemToReg_in} = 4'(i);
      #1;
      chk($sformatf("v%0d_alu", i), alu_result_out, vecs[i].e_alu);
      chk($sformatf("v%0d_fwdb", i), rs2_data_forwarded_out, vecs[i].e_fwdb);
      chk($sformatf("v%0d_taken", i), {31'd0, branch_taken_out}, {31'd0, vecs[i].e_tk});
      chk($sformatf("v%0d_target", i), branch_target_out, vecs[i].e_tgt);
      chk($sformatf("v%0d_rd", i), {27'd0, rd_out}, 32'(i + 3));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_exmem_alu", i), exmem_alu_result, vecs[i].e_alu);
      chk($sformatf("v%0d_exmem_rs2", i), exmem_rs2_data, vecs[i].e_fwdb);
      chk($sformatf("v%0d_exmem_rd", i), {27'd0, exmem_rd}, 32'(i + 3));
      chk($sformatf("v%0d_exmem_ctl", i),
          {28'd0, exmem_RegWrite, exmem_MemRead, exmem_MemWrite, exmem_MemToReg}, 32'(i % 16));
    end

    // Reset mid-stream discards the in-flight instruction; comb path unaffected
    @(negedge clk);
    apply(vecs[0]);
    rd_in = 5'd3;
    {RegWrite_in, MemRead_in, MemWrite_in, MemToReg_in} = 4'b1111;
    rst = 1'b1;
    #1;
    chk("rst_comb_alu", alu_result_out, 32'd30);
    chk("rst_comb_regwrite", {31'd0, RegWrite_out}, 32'd1);
    @(posedge clk);
    #1;
    chk_exmem_zero();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rel_exmem_alu", exmem_alu_result, 32'd30);
    chk("rel_exmem_rd", {27'd0, exmem_rd}, 32'd3);
    chk("rel_exmem_ctl", {28'd0, exmem_RegWrite, exmem_MemRead, exmem_MemWrite, exmem_MemToReg}, 32'hF);

    // Randomized traffic against the reference model
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 15) == 0);
      forwardA = 2'($urandom_range(0, 3));
      forwardB = 2'($urandom_range(0, 3));
      rs1_data_in = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 8)) : $urandom;
      rs2_data_in = ($urandom_range(0, 3) == 0) ? rs1_data_in : $urandom;
      imm_in = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      ex_mem_alu_result = $urandom;
      wb_data = ($urandom_range(0, 3) == 0) ? rs1_data_in : $urandom;
      pc_in = $urandom;
      funct3_in = 3'($urandom_range(0, 7));
      funct7_5_in = 1'($urandom_range(0, 1));
      ALUOp_in = 2'($urandom_range(0, 3));
      ALUSrc_in = 1'($urandom_range(0, 1));
      Branch_in = 1'($urandom_range(0, 1));
      rs1_in = 5'($urandom); rs2_in = 5'($urandom); rd_in = 5'($urandom);
      {RegWrite_in, MemRead_in, MemWrite_in, MemToReg_in} = 4'($urandom);
      #1;
      a = pick(forwardA, rs1_data_in);
      b = pick(forwardB, rs2_data_in);
      e_alu = ref_alu(a, ALUSrc_in ? imm_in : b);
      e_tk = ref_br(a, b);
      e_tgt = pc_in + imm_in;
      e_rd = rd_in;
      e_ctl = {RegWrite_in, MemRead_in, MemWrite_in, MemToReg_in};
      chk("rnd_alu", alu_result_out, e_alu);
      chk("rnd_fwdb", rs2_data_forwarded_out, b);
      chk("rnd_taken", {31'd0, branch_taken_out}, {31'd0, e_tk});
      chk("rnd_target", branch_target_out, e_tgt);
      chk("rnd_pass", {23'd0, rd_out, RegWrite_out, MemRead_out, MemWrite_out, MemToReg_out},
          {23'd0, e_rd, e_ctl});
      if (rst) begin
        e_alu = 32'd0; b = 32'd0; e_rd = 5'd0; e_ctl = 4'd0;
      end else begin
        e_ctl = e_ctl;
      end
      @(posedge clk);
      #1;
      chk("rnd_exmem_alu", exmem_alu_result, e_alu);
      chk("rnd_exmem_rs2", exmem_rs2_data, b);
      chk("rnd_exmem_rest",
          {23'd0, exmem_rd, exmem_RegWrite, exmem_MemRead, exmem_MemWrite, exmem_MemToReg},
          {23'd0, e_rd, e_ctl});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
